wb_writeback_unit: RTL and testbench

Register-file writeback stage for the single-cycle MIPS datapath: the write-side counterpart to the operand-select path that reads `read_data2`/`imm` into the ALU. Selects the writeback value (ALU result, load data, or link address `pc_plus4`) and registers the register-file write strobe, address and data. Handles variable-latency data-memory loads by stalling the core until read data returns, with a timeout guard. Exposes the pending write as a bypass source for operand selection.

---
 rtl/wb_writeback_unit.sv | 136 +++++++++++++
 tb/tb_wb_writeback_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_writeback_unit.sv
// Register-file writeback stage: selects ALU/load/link data, registers the write port,
// and stalls the core on variable-latency loads with a timeout abort.
module wb_writeback_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              link,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              byp_valid,
  output logic [ADDR_W-1:0] byp_addr,
  output logic [DATA_W-1:0] byp_data,
  output logic              mem_timeout
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] rd_cap_q, rd_cap_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic              accept, eff_load;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign accept   = wb_valid & reg_write;
  assign eff_load = mem_to_reg & ~link;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    rd_cap_d      = rd_cap_q;
    mem_timeout_d = mem_timeout_q;
    stall         = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = rd;
    wr_data       = alu_result;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!eff_load) begin
            wr_en   = 1'b1;
            wr_data = link ? pc_plus4 : alu_result;
          end else if (mem_rvalid) begin
            wr_en   = 1'b1;
            wr_data = mem_rdata;
          end else begin
            rd_cap_d   = rd;
            state_d    = WAIT_MEM;
            wait_cnt_d = '0;
            stall      = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          wr_en      = 1'b1;
          wr_addr    = rd_cap_q;
          wr_data    = mem_rdata;
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_LAST) begin
          mem_timeout_d = 1'b1;
          state_d       = IDLE;
          wait_cnt_d    = '0;
          stall         = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          stall      = 1'b1;
        end
      end
    endcase

    if (reset) stall = 1'b0;

    // Address/data track every write; r0 simply never raises the strobe.
    rf_we_d    = wr_en & (wr_addr != '0);
    rf_waddr_d = wr_en ? wr_addr : rf_waddr_q;
    rf_wdata_d = wr_en ? wr_data : rf_wdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      rd_cap_q      <= '0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      rd_cap_q      <= rd_cap_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign byp_valid   = rf_we_q;
  assign byp_addr    = rf_waddr_q;
  assign byp_data    = rf_wdata_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed self-checking bench for wb_writeback_unit: inputs change on the falling edge,
// stall is sampled before the rising edge, registered outputs 1 ns after it.
module tb_wb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, reg_write, mem_to_reg, link, mem_rvalid;
  logic [4:0]  rd;
  logic [31:0] alu_result, pc_plus4, mem_rdata;
  logic        stall, rf_we, byp_valid, mem_timeout;
  logic [4:0]  rf_waddr, byp_addr;
  logic [31:0] rf_wdata, byp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_writeback_unit #(.DATA_W(32), .ADDR_W(5), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .link(link), .rd(rd), .alu_result(alu_result),
    .pc_plus4(pc_plus4), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
    .mem_timeout(mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] addr,
                          input logic [31:0] data);
    check({tag, ".we"},    32'(rf_we),     32'(we));
    check({tag, ".addr"},  32'(rf_waddr),  32'(addr));
    check({tag, ".data"},  rf_wdata,       data);
    check({tag, ".bv"},    32'(byp_valid), 32'(we));
    check({tag, ".ba"},    32'(byp_addr),  32'(addr));
    check({tag, ".bd"},    byp_data,       data);
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic lk,
                       input logic [4:0] d, input logic [31:0] alu, input logic [31:0] pc,
                       input logic rv, input logic [31:0] rdat);
    @(negedge clk);
    wb_valid = v; reg_write = rw; mem_to_reg = m2r; link = lk; rd = d;
    alu_result = alu; pc_plus4 = pc; mem_rvalid = rv; mem_rdata = rdat;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    // Pending-load inputs during reset must not raise stall.
    drive(1, 1, 1, 0, 5'd3, 32'h0, 32'h0, 0, 32'h0);
    check("stall_in_reset", 32'(stall), 32'd0);
    tick();
    check_wr("reset", 0, 5'd0, 32'h0);
    check("reset.timeout", 32'(mem_timeout), 32'd0);

    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    reset = 1'b0;
    tick();

    // ALU write, then strobe drops while address/data hold
    drive(1, 1, 0, 0, 5'd8, 32'h0000_1234, 32'h0, 0, 32'h0);
    check("alu.stall", 32'(stall), 32'd0);
    tick();
    check_wr("alu", 1, 5'd8, 32'h0000_1234);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    tick();
    check_wr("alu_hold", 0, 5'd8, 32'h0000_1234);

    // Link priority over mem_to_reg, then back-to-back immediate load
    drive(1, 1, 1, 1, 5'd31, 32'h5555_5555, 32'h0040_0010, 0, 32'h0);
    check("link.stall", 32'(stall), 32'd0);
    tick();
    check_wr("link", 1, 5'd31, 32'h0040_0010);
    drive(1, 1, 1, 0, 5'd5, 32'h5555_5555, 32'h0, 1, 32'hCAFE_0001);
    check("ld_imm.stall", 32'(stall), 32'd0);
    tick();
    check_wr("ld_imm", 1, 5'd5, 32'hCAFE_0001);

    // Waited load to r9; instruction inputs change while stalled
    drive(1, 1, 1, 0, 5'd9, 32'h0, 32'h0, 0, 32'h0);
    check("wait.stall_acc", 32'(stall), 32'd1);
    tick();
    check("wait.we0", 32'(rf_we), 32'd0);
    drive(1, 1, 0, 0, 5'd3, 32'h3333_3333, 32'h0, 0, 32'h0);
    check("wait.stall_w1", 32'(stall), 32'd1);
    tick();
    check("wait.we1", 32'(rf_we), 32'd0);
    drive(1, 1, 0, 0, 5'd4, 32'h4444_4444, 32'h0, 0, 32'h0);
    check("wait.stall_w2", 32'(stall), 32'd1);
    tick();
    check("wait.we2", 32'(rf_we), 32'd0);
    drive(1, 1, 0, 0, 5'd4, 32'h4444_4444, 32'h0, 1, 32'hDEAD_BEEF);
    check("wait.stall_rv", 32'(stall), 32'd0);
    tick();
    check_wr("wait", 1, 5'd9, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    tick();
    check("wait.pulse", 32'(rf_we), 32'd0);

    // Timeout: 15 waited cycles with no read data
    drive(1, 1, 1, 0, 5'd12, 32'h0, 32'h0, 0, 32'h0);
    check("to.stall_acc", 32'(stall), 32'd1);
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
      check($sformatf("to.stall_%0d", i), 32'(stall), 32'd1);
      tick();
      check($sformatf("to.we_%0d", i), 32'(rf_we), 32'd0);
      if (i < 14) check($sformatf("to.early_%0d", i), 32'(mem_timeout), 32'd0);
    end
    check("to.sticky", 32'(mem_timeout), 32'd1);
    check_wr("to.nowrite", 0, 5'd9, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 32'h9999_9999);
    check("to.idle_stall", 32'(stall), 32'd0);
    tick();
    check_wr("to.late_rv", 0, 5'd9, 32'hDEAD_BEEF);
    drive(1, 1, 0, 0, 5'd7, 32'h0000_0077, 32'h0, 0, 32'h0);
    tick();
    check_wr("to.after", 1, 5'd7, 32'h0000_0077);
    check("to.still", 32'(mem_timeout), 32'd1);

    // r0 write, reg_write=0, load to r0
    drive(1, 1, 0, 0, 5'd0, 32'h0000_ABCD, 32'h0, 0, 32'h0);
    tick();
    check_wr("r0.alu", 0, 5'd0, 32'h0000_ABCD);
    drive(1, 0, 1, 0, 5'd4, 32'h0000_4444, 32'h0, 0, 32'h0);
    check("nowr.stall", 32'(stall), 32'd0);
    tick();
    check_wr("nowr", 0, 5'd0, 32'h0000_ABCD);
    drive(1, 1, 1, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    check("r0ld.stall_acc", 32'(stall), 32'd1);
    tick();
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    check("r0ld.stall_w", 32'(stall), 32'd1);
    tick();
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 32'h0000_1111);
    check("r0ld.stall_rv", 32'(stall), 32'd0);
    tick();
    check_wr("r0ld", 0, 5'd0, 32'h0000_1111);

    // Reset during WAIT_MEM
    drive(1, 1, 0, 0, 5'd6, 32'h0000_0066, 32'h0, 0, 32'h0);
    tick();
    check_wr("pre_rst", 1, 5'd6, 32'h0000_0066);
    drive(1, 1, 1, 0, 5'd10, 32'h0, 32'h0, 0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    check("rst_wait.stall_pre", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_wait.stall", 32'(stall), 32'd0);
    tick();
    check_wr("rst_wait", 0, 5'd0, 32'h0);
    check("rst_wait.timeout", 32'(mem_timeout), 32'd0);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 32'h7777_7777);
    reset = 1'b0;
    #1;
    check("rst_rv.stall", 32'(stall), 32'd0);
    tick();
    check_wr("rst_rv", 0, 5'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
